// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Package     : edge_pkg
// Description : Shared constants and strip layout helper for the 3-line strip
//               interface between edge_strip_builder and edge_detect.
//               PIXEL_W  - bits per grey pixel
//               ROWS     - rows per strip (up/middle/down)
//               NBANKS   - rotating row banks kept by the strip writer
//               strip_idx(width, r, k) - bit offset of row r, pixel k
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

    localparam int PIXEL_W = 8;
    localparam int ROWS    = 3;
    localparam int NBANKS  = 4;

    // Bit offset of pixel k in row r of a flat strip that is `width` pixels wide.
    function automatic int strip_idx(input int width, input int r, input int k);
        return (r * width + k) * PIXEL_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_line_bank.sv
`default_nettype none
// ============================================================================
// Module      : edge_line_bank
// Description : One line of pixel storage (STRIP_WIDTH x PIXEL_W registers)
//               with a single write port and the whole row exposed flat.
// Ports       : clk     - clock
//               i_we    - write enable
//               i_idx   - pixel (column) index to write
//               i_data  - pixel value
//               o_row   - full row, pixel k at [k*PIXEL_W +: PIXEL_W]
// Revision    : 1.0 - initial release
// ============================================================================
module edge_line_bank
    import edge_pkg::*;
#(
    parameter int STRIP_WIDTH = 640,
    parameter int IDX_W       = 10
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [IDX_W-1:0]               i_idx,
    input  logic [PIXEL_W-1:0]             i_data,
    output logic [STRIP_WIDTH*PIXEL_W-1:0] o_row
);

    // Pixel storage carries no reset: a row is only ever presented after it
    // has been completely rewritten, so its power-up content is never visible.
    logic [PIXEL_W-1:0] r_pix [STRIP_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_pix[i_idx] <= i_data;
        end
    end

    generate
        for (genvar k = 0; k < STRIP_WIDTH; k++) begin : g_pix
            assign o_row[k*PIXEL_W +: PIXEL_W] = r_pix[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/edge_strip_builder.sv
`default_nettype none
// ============================================================================
// Module      : edge_strip_builder
// Description : Writer side of the 3-line strip interface. Stores the raster
//               pixel stream into four rotating row banks and, whenever a
//               line completes, presents the three most recent rows as one
//               up/middle/down strip with a valid/ready handshake.
// Ports       : clock       - clock
//               nReset      - asynchronous active-low reset
//               frame_start - 1-cycle frame start pulse
//               pix_valid   - pix_data valid this cycle
//               pix_data    - grey pixel, raster order
//               strip_valid - strip_data holds a complete strip
//               strip_ready - consumer takes the strip at this edge
//               strip_data  - row r pixel k at [(r*STRIP_WIDTH+k)*8 +: 8]
//               strip_line  - frame line index of the middle row
//               overrun     - sticky: a completed line was dropped
// Revision    : 1.0 - initial release
// ============================================================================
module edge_strip_builder
    import edge_pkg::*;
#(
    parameter int STRIP_WIDTH = 640,
    parameter int LINE_BITS   = 11
) (
    input  logic                                clock,
    input  logic                                nReset,
    input  logic                                frame_start,
    input  logic                                pix_valid,
    input  logic [PIXEL_W-1:0]                  pix_data,
    output logic                                strip_valid,
    input  logic                                strip_ready,
    output logic [STRIP_WIDTH*ROWS*PIXEL_W-1:0] strip_data,
    output logic [LINE_BITS-1:0]                strip_line,
    output logic                                overrun
);

    localparam int                c_col_w    = (STRIP_WIDTH > 1) ? $clog2(STRIP_WIDTH) : 1;
    localparam int                c_row_w    = STRIP_WIDTH * PIXEL_W;
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(STRIP_WIDTH - 1);

    logic [c_col_w-1:0]   r_col;
    logic [1:0]           r_lines;      // completed lines this frame, saturating at 3
    logic [1:0]           r_wptr;       // bank currently being written
    logic [LINE_BITS-1:0] r_line_cnt;   // frame line number of the line being written
    logic                 r_strip_valid;
    logic [LINE_BITS-1:0] r_strip_line;
    logic                 r_overrun;
    logic [1:0]           r_sel [ROWS]; // bank feeding each strip row

    logic                 w_line_done;
    logic                 w_can_load;
    logic [1:0]           w_lines_inc;
    logic                 w_load;
    logic [NBANKS-1:0]    w_we;
    logic [c_col_w-1:0]   w_widx;
    logic [c_row_w-1:0]   w_bank_row [NBANKS];

    assign w_line_done = pix_valid && !frame_start && (r_col == c_col_last);
    // A new strip may only replace the presented one when it is being taken now.
    assign w_can_load  = !r_strip_valid || strip_ready;
    assign w_lines_inc = (r_lines == 2'd3) ? 2'd3 : r_lines + 2'd1;
    assign w_load      = w_line_done && w_can_load && (w_lines_inc == 2'd3);

    // A pixel arriving with frame_start is column 0 of line 0, i.e. bank 0.
    always_comb begin
        w_we   = '0;
        w_widx = frame_start ? '0 : r_col;
        if (pix_valid) begin
            if (frame_start) begin
                w_we[0] = 1'b1;
            end else begin
                w_we[r_wptr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_col         <= '0;
            r_lines       <= '0;
            r_wptr        <= '0;
            r_line_cnt    <= '0;
            r_strip_valid <= 1'b0;
            r_strip_line  <= '0;
            r_overrun     <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                r_sel[r] <= '0;
            end
        end else if (frame_start) begin
            r_col         <= pix_valid ? c_col_w'(1) : '0;
            r_lines       <= '0;
            r_wptr        <= '0;
            r_line_cnt    <= '0;
            r_strip_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (pix_valid) begin
                if (w_line_done) begin
                    r_col      <= '0;
                    r_lines    <= w_lines_inc;
                    r_line_cnt <= r_line_cnt + 1'b1;
                    // While a strip is pending the write bank is held, so the
                    // dropped line is overwritten by the next one and the
                    // pending rows stay untouched.
                    if (w_can_load) begin
                        r_wptr <= r_wptr + 2'd1;
                    end else begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_load) begin
                r_strip_valid <= 1'b1;
                r_sel[0]      <= r_wptr - 2'd2;
                r_sel[1]      <= r_wptr - 2'd1;
                r_sel[2]      <= r_wptr;
                r_strip_line  <= r_line_cnt - 1'b1;
            end else if (r_strip_valid && strip_ready) begin
                r_strip_valid <= 1'b0;
            end
        end
    end

    generate
        for (genvar b = 0; b < NBANKS; b++) begin : g_bank
            edge_line_bank #(
                .STRIP_WIDTH (STRIP_WIDTH),
                .IDX_W       (c_col_w)
            ) u_bank (
                .clk    (clock),
                .i_we   (w_we[b]),
                .i_idx  (w_widx),
                .i_data (pix_data),
                .o_row  (w_bank_row[b])
            );
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign strip_data[strip_idx(STRIP_WIDTH, r, 0) +: c_row_w] =
                r_strip_valid ? w_bank_row[r_sel[r]] : '0;
        end
    endgenerate

    assign strip_valid = r_strip_valid;
    assign strip_line  = r_strip_line;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
